// File: rtl/sevenseg_fmt.sv
// Signed binary to eight 7-segment digit words via an iterative double-dabble.
// Build option SEVENSEG_FMT_LZB_EN: leading-zero blanking with a floating minus sign.
module sevenseg_fmt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] value,
  input  logic         dp_en,
  input  logic [2:0]   dp_sel,
  output logic         busy,
  output logic         done,
  output logic [6:0]   d7,
  output logic [6:0]   d6,
  output logic [6:0]   d5,
  output logic [6:0]   d4,
  output logic [6:0]   d3,
  output logic [6:0]   d2,
  output logic [6:0]   d1,
  output logic [6:0]   d0
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FORMAT = 2'd2;

  // Handshake: start is taken only in IDLE; busy covers SHIFT and FORMAT;
  // done pulses for one cycle exactly when d7..d0 take new values.
  logic [1:0]    state;
  logic [W-1:0]  bin;
  logic [31:0]   bcd;
  logic [31:0]   bcd_adj;
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          dp_en_q;
  logic [2:0]    dp_sel_q;
  logic [W-1:0]  mag;
  logic [6:0]    word [8];

  // Unsigned negation in W bits maps -2^(W-1) onto 2^(W-1) without overflow.
  assign mag  = value[W-1] ? (~value + 1'b1) : value;
  assign busy = (state != ST_IDLE);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3) : bcd[4*i +: 4];
    end
  end

`ifdef SEVENSEG_FMT_LZB_EN
  logic [2:0] msd;
  logic [2:0] keep;

  always_comb begin
    msd = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    keep = (dp_en_q && (dp_sel_q > msd)) ? dp_sel_q : msd;
    for (int i = 0; i < 8; i++) begin
      word[i] = {1'b0, dp_en_q && (dp_sel_q == 3'(i)), 1'b0, bcd[4*i +: 4]};
      if (3'(i) > keep) word[i] = 7'h40;
      // The dash has nowhere to go when the decimal point already claims d7.
      if (neg_q && (keep != 3'd7) && (3'(i) == keep + 3'd1)) word[i] = 7'h10;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      word[i] = {1'b0, dp_en_q && (dp_sel_q == 3'(i)), 1'b0, bcd[4*i +: 4]};
    end
    // d7's nibble is always zero, so the dash simply merges with any dp there.
    if (neg_q) word[7] = word[7] | 7'h10;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      dp_en_q  <= 1'b0;
      dp_sel_q <= 3'd0;
      done     <= 1'b0;
      d7       <= 7'h40;
      d6       <= 7'h40;
      d5       <= 7'h40;
      d4       <= 7'h40;
      d3       <= 7'h40;
      d2       <= 7'h40;
      d1       <= 7'h40;
      d0       <= 7'h40;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin      <= mag;
            bcd      <= '0;
            cnt      <= '0;
            neg_q    <= value[W-1];
            dp_en_q  <= dp_en;
            dp_sel_q <= dp_sel;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd, bin} <= {bcd_adj[30:0], bin, 1'b0};
          cnt        <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= ST_FORMAT;
        end
        ST_FORMAT: begin
          d7    <= word[7];
          d6    <= word[6];
          d5    <= word[5];
          d4    <= word[4];
          d3    <= word[3];
          d2    <= word[2];
          d1    <= word[1];
          d0    <= word[0];
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sevenseg_fmt.sv
// Directed bench for sevenseg_fmt: a W=16 and a W=24 instance, expectations
// hand-computed for either setting of SEVENSEG_FMT_LZB_EN.
module tb_sevenseg_fmt;

`ifdef SEVENSEG_FMT_LZB_EN
  localparam logic [6:0] LZ = 7'h40;
`else
  localparam logic [6:0] LZ = 7'h00;
`endif

  logic        clk;
  logic        rst;
  logic        start16, start24;
  logic [15:0] value16;
  logic [23:0] value24;
  logic        dp_en;
  logic [2:0]  dp_sel;
  logic        busy16, done16, busy24, done24;
  logic [6:0]  a7, a6, a5, a4, a3, a2, a1, a0;
  logic [6:0]  b7, b6, b5, b4, b3, b2, b1, b0;
  logic [55:0] obs16, obs24;

  int vectors;
  int miscompares;
  int lat, bcnt;

  assign obs16 = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign obs24 = {b7, b6, b5, b4, b3, b2, b1, b0};

  sevenseg_fmt #(.W(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .value(value16), .dp_en(dp_en), .dp_sel(dp_sel),
    .busy(busy16), .done(done16),
    .d7(a7), .d6(a6), .d5(a5), .d4(a4), .d3(a3), .d2(a2), .d1(a1), .d0(a0)
  );

  sevenseg_fmt #(.W(24)) u24 (
    .clk(clk), .rst(rst), .start(start24), .value(value24), .dp_en(dp_en), .dp_sel(dp_sel),
    .busy(busy24), .done(done24),
    .d7(b7), .d6(b6), .d5(b5), .d4(b4), .d3(b3), .d2(b2), .d1(b1), .d0(b0)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: called at a negedge; start is sampled at the next posedge (edge k).
  // lat is the cycle index (k+n) in which done is seen, bcnt the busy cycles.
  task automatic drive_conv(input bit w24, input logic [23:0] v, input logic de,
                            input logic [2:0] ds, output int lat_o, output int bcnt_o);
    lat_o  = 0;
    bcnt_o = 0;
    dp_en  = de;
    dp_sel = ds;
    if (w24) begin start24 = 1'b1; value24 = v; end
    else     begin start16 = 1'b1; value16 = v[15:0]; end
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin start16 = 1'b0; start24 = 1'b0; end
      if (w24 ? busy24 : busy16) bcnt_o++;
      if (w24 ? done24 : done16) begin lat_o = n; break; end
    end
    if (lat_o == 0) begin
      vectors++; miscompares++;
      $display("FAIL timeout: done not seen within 60 cycles (value %0h)", v);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start16 = 1'b0; start24 = 1'b0; value16 = '0; value24 = '0;
    dp_en = 1'b0; dp_sel = 3'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy16, done16, busy24, done24} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b want 0000", {busy16, done16, busy24, done24});
    end
    vectors++;
    if (obs16 !== {8{7'h40}}) begin miscompares++; $display("FAIL reset_d16: got %h want %h", obs16, {8{7'h40}}); end
    vectors++;
    if (obs24 !== {8{7'h40}}) begin miscompares++; $display("FAIL reset_d24: got %h want %h", obs24, {8{7'h40}}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_1234;
    logic [55:0] exp_d;
    exp_d = {LZ, LZ, LZ, LZ, 7'h01, 7'h02, 7'h03, 7'h04};
    drive_conv(1'b0, 24'd1234, 1'b0, 3'd0, lat, bcnt);
    vectors++;
    if (lat !== 18) begin miscompares++; $display("FAIL latency_1234: got %0d want 18", lat); end
    vectors++;
    if (bcnt !== 17) begin miscompares++; $display("FAIL busy_len_1234: got %0d want 17", bcnt); end
    vectors++;
    if (busy16 !== 1'b0) begin miscompares++; $display("FAIL busy_at_done: got %b want 0", busy16); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs16[7*i +: 7] !== exp_d[7*i +: 7]) begin
        miscompares++; $display("FAIL d%0d_1234: got %h want %h", i, obs16[7*i +: 7], exp_d[7*i +: 7]);
      end
    end
    @(negedge clk);
    vectors++;
    if (done16 !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width: got %b want 0", done16); end
    vectors++;
    if (obs16 !== exp_d) begin miscompares++; $display("FAIL d_held_1234: got %h want %h", obs16, exp_d); end
  endtask

  task automatic test_back_to_back;
    logic [55:0] exp_d;
`ifdef SEVENSEG_FMT_LZB_EN
    exp_d = {7'h40, 7'h40, 7'h10, 7'h03, 7'h02, 7'h07, 7'h06, 7'h08};
`else
    exp_d = {7'h10, 7'h00, 7'h00, 7'h03, 7'h02, 7'h07, 7'h06, 7'h08};
`endif
    drive_conv(1'b0, 24'd32767, 1'b0, 3'd0, lat, bcnt);
    vectors++;
    if (obs16 !== {LZ, LZ, LZ, 7'h03, 7'h02, 7'h07, 7'h06, 7'h07}) begin
      miscompares++; $display("FAIL d_32767: got %h want %h", obs16, {LZ, LZ, LZ, 7'h03, 7'h02, 7'h07, 7'h06, 7'h07});
    end
    // Second start issued in the done cycle of the first.
    drive_conv(1'b0, 24'h008000, 1'b0, 3'd0, lat, bcnt);
    vectors++;
    if (lat !== 18) begin miscompares++; $display("FAIL latency_b2b: got %0d want 18", lat); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs16[7*i +: 7] !== exp_d[7*i +: 7]) begin
        miscompares++; $display("FAIL d%0d_neg32768: got %h want %h", i, obs16[7*i +: 7], exp_d[7*i +: 7]);
      end
    end
  endtask

  task automatic test_dp;
    logic [55:0] exp_d;
    exp_d = {LZ, LZ, LZ, LZ, LZ, 7'h20, 7'h00, 7'h00};
    drive_conv(1'b0, 24'd0, 1'b1, 3'd2, lat, bcnt);
    vectors++;
    if (obs16 !== exp_d) begin miscompares++; $display("FAIL d_zero_dp2: got %h want %h", obs16, exp_d); end
`ifdef SEVENSEG_FMT_LZB_EN
    exp_d = {7'h40, 7'h40, 7'h40, 7'h10, 7'h20, 7'h00, 7'h00, 7'h05};
`else
    exp_d = {7'h10, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h05};
`endif
    drive_conv(1'b0, 24'h00FFFB, 1'b1, 3'd3, lat, bcnt);
    vectors++;
    if (obs16 !== exp_d) begin miscompares++; $display("FAIL d_neg5_dp3: got %h want %h", obs16, exp_d); end
`ifdef SEVENSEG_FMT_LZB_EN
    exp_d = {7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h05};
`else
    exp_d = {7'h30, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h05};
`endif
    drive_conv(1'b0, 24'h00FFFB, 1'b1, 3'd7, lat, bcnt);
    vectors++;
    if (obs16 !== exp_d) begin miscompares++; $display("FAIL d_neg5_dp7: got %h want %h", obs16, exp_d); end
  endtask

  task automatic test_w24_min;
    logic [55:0] exp_d;
    exp_d = {7'h10, 7'h08, 7'h03, 7'h08, 7'h08, 7'h06, 7'h00, 7'h08};
    drive_conv(1'b1, 24'h800000, 1'b0, 3'd0, lat, bcnt);
    vectors++;
    if (lat !== 26) begin miscompares++; $display("FAIL latency_w24: got %0d want 26", lat); end
    vectors++;
    if (bcnt !== 25) begin miscompares++; $display("FAIL busy_len_w24: got %0d want 25", bcnt); end
    vectors++;
    if (obs24 !== exp_d) begin miscompares++; $display("FAIL d_w24_min: got %h want %h", obs24, exp_d); end
  endtask

  task automatic test_ignored_start;
    int dcnt;
    int first;
    dcnt = 0; first = 0;
    dp_en = 1'b0; dp_sel = 3'd0;
    start16 = 1'b1; value16 = 16'd42;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) start16 = 1'b0;
      if (n == 5) begin start16 = 1'b1; value16 = 16'hFFFF; end
      if (n == 6) start16 = 1'b0;
      if (done16) begin dcnt++; if (first == 0) first = n; end
    end
    vectors++;
    if (dcnt !== 1) begin miscompares++; $display("FAIL ignored_start_dones: got %0d want 1", dcnt); end
    vectors++;
    if (first !== 18) begin miscompares++; $display("FAIL ignored_start_latency: got %0d want 18", first); end
    vectors++;
    if (obs16 !== {LZ, LZ, LZ, LZ, LZ, LZ, 7'h04, 7'h02}) begin
      miscompares++; $display("FAIL d_42: got %h want %h", obs16, {LZ, LZ, LZ, LZ, LZ, LZ, 7'h04, 7'h02});
    end
  endtask

  task automatic test_reset_abort;
    int dcnt;
    dcnt = 0;
    dp_en = 1'b0; dp_sel = 3'd0;
    start16 = 1'b1; value16 = 16'd999;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) start16 = 1'b0;
      if (n == 8) rst = 1'b0;
      if (n == 12) rst = 1'b1;
      if (done16) dcnt++;
      if (n == 9) begin
        vectors++;
        if (busy16 !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy16); end
        vectors++;
        if (obs16 !== {8{7'h40}}) begin miscompares++; $display("FAIL abort_blank: got %h want %h", obs16, {8{7'h40}}); end
      end
    end
    vectors++;
    if (dcnt !== 0) begin miscompares++; $display("FAIL abort_done: got %0d want 0", dcnt); end
    drive_conv(1'b0, 24'd7, 1'b0, 3'd0, lat, bcnt);
    vectors++;
    if (lat !== 18) begin miscompares++; $display("FAIL latency_after_abort: got %0d want 18", lat); end
    vectors++;
    if (obs16 !== {LZ, LZ, LZ, LZ, LZ, LZ, LZ, 7'h07}) begin
      miscompares++; $display("FAIL d_7: got %h want %h", obs16, {LZ, LZ, LZ, LZ, LZ, LZ, LZ, 7'h07});
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset;
    test_basic_1234;
    test_back_to_back;
    test_dp;
    test_w24_min;
    test_ignored_start;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sevenseg_fmt.md
# sevenseg_fmt

Iterative signed-binary-to-decimal formatter that computes the eight 7-bit digit words (d7..d0) consumed by `sevenseg_ctl`. It handles magnitude conversion, leading-zero blanking, minus-sign placement and decimal-point insertion. Inputs are a start/busy/done handshake from the application datapath. Outputs are registered and held stable between conversions, so the display refresh never sees partial results.

## Interface
- `W`, default 16: input width, signed two's complement; legal range 2..24, so the magnitude is at most 2^23 (7 decimal digits).
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: conversion request; sampled only in IDLE.
- `value` input W: signed value; sampled with an accepted `start`.
- `dp_en` input 1: enable decimal point; sampled with `start`.
- `dp_sel` input 3: digit index 0..7 that receives the decimal point; sampled with `start`.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when d7..d0 update.
- `d7`..`d0` output 7 each: digit words. Bit 6 = blank, bit 5 = dp, bit 4 = dash, bits 3:0 = hex digit.

## Operation
- **States:** IDLE, SHIFT, FORMAT.
- **IDLE**
  - `start`=1 is accepted: latch |value| into a W-bit unsigned shift register, clear the 32-bit BCD register, latch sign, `dp_en` and `dp_sel`, and go to SHIFT.
  - `start` in any other state is ignored (no queuing).
- **Magnitude:** |value| is computed unsigned in W bits. The most negative value, -2^(W-1), gives magnitude 2^(W-1) with no overflow.
- **SHIFT:** double-dabble, one bit per cycle, for exactly W cycles. Each cycle adds 3 to every BCD nibble ≥5, then shifts {bcd, bin} left by 1. An iteration counter of $clog2(W+1) bits runs from 0 to W-1, then the state goes to FORMAT.
- **FORMAT** (1 cycle): builds the digit words, registers them into d7..d0, pulses `done`, and returns to IDLE.
- **Digit words:**
  - Digit i: bits 3:0 = BCD nibble i, bit 5 = (dp_en && dp_sel==i), bit 4 = 0, bit 6 = 0, except as modified below.
  - msd = index of the highest nonzero nibble, or 0 if the value is zero.
  - keep = max(msd, dp_en ? dp_sel : 0).
  - With blanking: digits i > keep become blank (7'h40). If negative, digit keep+1 becomes dash (7'h10). keep+1 ≤ 7 always holds unless dp_sel=7 on a negative value; in that case the dash is dropped.
  - A negative value never converts to zero, so a zero result shows no dash.

## Timing
- Reset values: `busy`=0, `done`=0, d7..d0=7'h40 (all blank), state IDLE.
- `start` sampled at edge k:
  - `busy`=1 from cycle k+1 through k+W+1.
  - New d7..d0 and `done`=1 are visible in cycle k+W+2; `busy`=0 in that cycle.
- Latency W+2 cycles; minimum start-to-start spacing W+2 cycles. A `start` in the `done` cycle is accepted.
- Outputs change only on the FORMAT edge or on reset.
- Reset asserted mid-conversion aborts immediately: outputs blank, no `done`.

## Configuration
- Macro: `SEVENSEG_FMT_LZB_EN`.
- **Defined:** leading-zero blanking and floating minus placement as described under Operation.
- **Undefined:**
  - No blanking: all eight digits show their nibble, including leading zeros.
  - Negative values put the dash in d7 (7'h10). d7's nibble is always 0, since the magnitude is below 10^7.
  - dp handling is unchanged, but dp on d7 is OR'd into the dash word.

## Test plan
- **1234, W=16, LZB:** start at edge k → `done` in cycle k+18; d3..d0 = 7'h01, 7'h02, 7'h03, 7'h04; d7..d4 = 7'h40; `busy` high for 17 cycles.
- **-32768, W=16, LZB:** d5 = 7'h10; d4..d0 = 7'h03, 7'h02, 7'h07, 7'h06, 7'h08; d7, d6 = 7'h40.
- **0, dp_en=1, dp_sel=2, LZB:** d2 = 7'h20, d1 = 7'h00, d0 = 7'h00, d7..d3 = 7'h40 (display "0.00").
- **-8388608, W=24, LZB undefined:** d7 = 7'h10; d6..d0 = 7'h08, 7'h03, 7'h08, 7'h08, 7'h06, 7'h00, 7'h08.
- **Start 42, then pulse `start` with -1 at k+5:** second request ignored; result shows 42 (d1 = 7'h04, d0 = 7'h02) with a single `done`.
- **Reset at k+8 during a conversion:** all d = 7'h40, `busy`=0, no `done`. A following start of 7 yields d0 = 7'h07 after W+2 cycles.
